// File: rtl/mux41_4_reg_if.sv
// -----------------------------------------------------------------------------
// mux41_4_reg_if
// Bundles the data/select/valid inputs and the registered outputs of the
// registered 4-to-1 multiplexer.
//
// Signals:
//   w0..w3    data words, WIDTH bits each (driven by master)
//   s         2-bit select code            (driven by master)
//   in_valid  qualifies w0..w3 and s       (driven by master)
//   y         registered selected word     (driven by slave)
//   y_valid   high for the cycle after an accepted capture (driven by slave)
//   y_sel     select code that produced y  (driven by slave)
//
// Modports:
//   master : the producer of data/select, consumer of the registered result
//   slave  : the multiplexer itself
// -----------------------------------------------------------------------------
interface mux41_4_reg_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] w0;
   logic [WIDTH-1:0] w1;
   logic [WIDTH-1:0] w2;
   logic [WIDTH-1:0] w3;
   logic [1:0]       s;
   logic             in_valid;
   logic [WIDTH-1:0] y;
   logic             y_valid;
   logic [1:0]       y_sel;

   modport master (
      output w0, w1, w2, w3, s, in_valid,
      input  y, y_valid, y_sel
   );

   modport slave (
      input  w0, w1, w2, w3, s, in_valid,
      output y, y_valid, y_sel
   );
endinterface

// File: rtl/mux41_4_reg.sv
// -----------------------------------------------------------------------------
// mux41_4_reg
// Registered 4-to-1 multiplexer for WIDTH-bit words, used as a pipelined
// data-path selector. One of w0..w3 (chosen by s) is captured into the output
// register on a rising clk edge when in_valid is high. y and y_sel hold while
// in_valid is low; y_valid marks the cycle following each accepted capture.
// Latency is exactly one clock, throughput one word per clock, no backpressure.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; clears y, y_valid and y_sel at once
//   bus    slave side of mux41_4_reg_if:
//            in : w0, w1, w2, w3, s, in_valid
//            out: y, y_valid, y_sel (all straight from flops)
// -----------------------------------------------------------------------------
module mux41_4_reg #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mux41_4_reg_if.slave  bus
);

   logic [WIDTH-1:0] w_sel_data;

   logic [WIDTH-1:0] r_y;
   logic             r_y_valid;
   logic [1:0]       r_y_sel;

   // All four codes are legal, so the case is full and needs no error branch.
   always_comb begin
      w_sel_data = bus.w0;
      case (bus.s)
         2'b00:   w_sel_data = bus.w0;
         2'b01:   w_sel_data = bus.w1;
         2'b10:   w_sel_data = bus.w2;
         default: w_sel_data = bus.w3;
      endcase
   end

   // Reset overrides any capture; a clock edge while rst_n is low does nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_y_sel   <= 2'b00;
      end else begin
         r_y_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_y     <= w_sel_data;
            r_y_sel <= bus.s;
         end
      end
   end

   // Outputs come only from flops: no combinational input-to-output path.
   assign bus.y       = r_y;
   assign bus.y_valid = r_y_valid;
   assign bus.y_sel   = r_y_sel;

endmodule

// File: tb/tb_mux41_4_reg.sv
// -----------------------------------------------------------------------------
// tb_mux41_4_reg
// Self-checking bench for mux41_4_reg: directed cases for reset, per-code
// capture, hold, back-to-back streaming and isolation, a WIDTH=8 instance,
// then randomized traffic checked against a simple array-indexed model.
// -----------------------------------------------------------------------------
module tb_mux41_4_reg;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fail;

   // reference model state for the WIDTH=4 instance
   logic [3:0] exp_y;
   logic       exp_v;
   logic [1:0] exp_sel;

   mux41_4_reg_if #(.WIDTH(4)) bus4 ();
   mux41_4_reg_if #(.WIDTH(8)) bus8 ();

   mux41_4_reg #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   mux41_4_reg #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".y"},       32'(bus4.y),       32'(exp_y));
      check({tag, ".y_valid"}, 32'(bus4.y_valid), 32'(exp_v));
      check({tag, ".y_sel"},   32'(bus4.y_sel),   32'(exp_sel));
      $display("%s: v=%0b s=%0d w={%h,%h,%h,%h} -> y=%h y_valid=%0b y_sel=%0d",
               tag, bus4.in_valid, bus4.s, bus4.w0, bus4.w1, bus4.w2, bus4.w3,
               bus4.y, bus4.y_valid, bus4.y_sel);
   endtask

   // Drive one cycle's inputs, take the edge, advance the model, check outputs.
   task automatic cycle(input string tag, input logic v, input logic [1:0] sel,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
      logic [3:0] words [4];
      bus4.in_valid = v;
      bus4.s  = sel;
      bus4.w0 = a;
      bus4.w1 = b;
      bus4.w2 = c;
      bus4.w3 = d;
      @(posedge clk);
      words = '{a, b, c, d};
      if (v) begin
         exp_y   = words[sel];
         exp_sel = sel;
      end
      exp_v = v;
      #1;
      check_all(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus4.in_valid = 1'b0; bus4.s = 2'b00;
      bus4.w0 = '0; bus4.w1 = '0; bus4.w2 = '0; bus4.w3 = '0;
      bus8.in_valid = 1'b0; bus8.s = 2'b00;
      bus8.w0 = '0; bus8.w1 = '0; bus8.w2 = '0; bus8.w3 = '0;
      exp_y = '0; exp_v = 1'b0; exp_sel = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      check("reset8.y", 32'(bus8.y), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // per-code capture
      cycle("cap_s00", 1'b1, 2'b00, 4'b0001, 4'b0010, 4'b0000, 4'b1000);
      cycle("cap_s01", 1'b1, 2'b01, 4'b0001, 4'b0010, 4'b0000, 4'b1000);
      cycle("cap_s10", 1'b1, 2'b10, 4'b0001, 4'b0010, 4'b0011, 4'b1000);
      cycle("cap_s11", 1'b1, 2'b11, 4'b0001, 4'b0010, 4'b0011, 4'b1000);

      // hold
      cycle("hold_cap", 1'b1, 2'b00, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
      cycle("hold",     1'b0, 2'b10, 4'b1100, 4'b0000, 4'b0100, 4'b0000);
      check("hold.y_lit", 32'(bus4.y), 32'hC);

      // back-to-back stream
      cycle("b2b0", 1'b1, 2'b00, 4'b0101, 4'b1111, 4'b1111, 4'b1111);
      cycle("b2b1", 1'b1, 2'b11, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
      cycle("b2b2", 1'b1, 2'b10, 4'b1111, 4'b1111, 4'b0100, 4'b1111);
      cycle("b2b3", 1'b1, 2'b01, 4'b1111, 4'b0010, 4'b1111, 4'b1111);
      check("b2b3.y_lit", 32'(bus4.y), 32'h2);

      // isolation: only w2 matters while s stays at 10
      cycle("iso_cap", 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1101, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         cycle("iso", 1'b1, 2'b10, 4'($urandom), 4'($urandom), 4'b1101, 4'($urandom));
         check("iso.y_lit", 32'(bus4.y), 32'hD);
      end

      // identical input still pulses y_valid
      cycle("same", 1'b1, 2'b01, 4'b0000, 4'b1101, 4'b0000, 4'b0000);

      // WIDTH=8 instance
      bus8.in_valid = 1'b1; bus8.s = 2'b11;
      bus8.w0 = 8'h11; bus8.w1 = 8'h22; bus8.w2 = 8'h33; bus8.w3 = 8'hA5;
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      check("w8.y",       32'(bus8.y),       32'hA5);
      check("w8.y_valid", 32'(bus8.y_valid), 32'h1);
      check("w8.y_sel",   32'(bus8.y_sel),   32'h3);
      $display("w8: y=%h y_valid=%0b y_sel=%0d", bus8.y, bus8.y_valid, bus8.y_sel);

      // reset mid-cycle with y = 1010
      cycle("pre_rst", 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1010, 4'b0000);
      bus4.in_valid = 1'b1; bus4.s = 2'b11; bus4.w3 = 4'b0110;
      #2;
      rst_n = 1'b0;
      exp_y = '0; exp_v = 1'b0; exp_sel = 2'b00;
      #1;
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_edge");
      #2;
      rst_n = 1'b1;
      #1;
      check_all("rst_release");
      cycle("post_rst", 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0110);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [3:0] a, b, c, d;
         logic [1:0] sel;
         logic       v;
         logic [3:0] words [4];
         a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
         sel = 2'($urandom);
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            words = '{a, b, c, d};
            words[sel] = exp_y;
            a = words[0]; b = words[1]; c = words[2]; d = words[3];
         end
         cycle("rand", v, sel, a, b, c, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mux41_4_reg.md
Name: mux41_4_reg

Overview:
- Registered 4-to-1 multiplexer for WIDTH-bit data words.
- Captures one of four data inputs, chosen by a 2-bit select, into an output register on the rising clock edge when the input is qualified valid.
- Used as a pipelined data-path selector.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, bit width of each data input and of the data output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- w0  input  WIDTH  data input selected when s = 2'b00.
- w1  input  WIDTH  data input selected when s = 2'b01.
- w2  input  WIDTH  data input selected when s = 2'b10.
- w3  input  WIDTH  data input selected when s = 2'b11.
- s  input  2  select code.
- in_valid  input  1  qualifies w0..w3 and s for capture this cycle.
- y  output  WIDTH  registered selected data word.
- y_valid  output  1  high for exactly the cycles after an accepted capture.
- y_sel  output  2  registered copy of the select code used for the current y.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low immediately, without waiting for a clock edge, forces y = 0, y_valid = 0 and y_sel = 2'b00.
  - Outputs hold these values while rst_n is low.
  - Reset release is synchronous to the next rising clk edge; the first capture is possible on the first rising edge with rst_n high.
- Selection map: s=00 -> w0, s=01 -> w1, s=10 -> w2, s=11 -> w3. All four codes are legal; there is no default or error case.
- Capture: on a rising clk edge with in_valid = 1:
  - y <= selected input;
  - y_sel <= s;
  - y_valid <= 1.
- Hold: on a rising clk edge with in_valid = 0:
  - y and y_sel hold their previous values;
  - y_valid <= 0.
- Latency: exactly 1 clock from sampled inputs to y/y_valid/y_sel.
- Throughput: one capture per clock. Back-to-back valid cycles each produce a new y; there is no backpressure.
- No combinational path from any input to any output.
- Input changes between clock edges have no effect on outputs.
- Width rules: data is passed through unmodified. No sign handling, no truncation, and no padding; all four inputs and y are WIDTH bits.
- Reset mid-operation: an asynchronous assertion of rst_n overrides any in-progress capture. y, y_valid and y_sel clear in the same instant, and the pending capture is discarded.
- Simultaneous events: a rising clk edge while rst_n is low has no effect; reset dominates.
- Identical inputs: if the selected input equals the previous y, y is unchanged but y_valid still asserts for that capture.

Test Plan:
- Reset: drive rst_n low mid-cycle with y = 4'b1010 -> y = 0000, y_valid = 0 and y_sel = 00 immediately, before the next clk edge. They stay there until the first edge after release.
- Per-code capture, with in_valid = 1 and results checked one cycle later:
  - w0=0001, w1=0010, w2=0000, w3=1000, s=00 -> y = 0001, y_sel = 00, y_valid = 1.
  - w1=0010, s=01 -> y = 0010, y_sel = 01.
  - w2=0011, s=10 -> y = 0011, y_sel = 10.
  - w3=1000, s=11 -> y = 1000, y_sel = 11.
- Hold: capture w0=1100 with s=00, then drive in_valid = 0 while changing s to 10 and w2 to 0100 -> y stays 1100, y_sel stays 00, y_valid = 0.
- Back-to-back stream over consecutive valid cycles:
  - inputs: (s=00, w0=0101), (s=11, w3=0000), (s=10, w2=0100), (s=01, w1=0010);
  - required y sequence one cycle later: 0101, 0000, 0100, 0010;
  - y_valid stays 1 throughout.
- Isolation: with s=10 and w2=1101 captured, toggle w0, w1 and w3 every cycle with in_valid = 1 and s fixed -> y remains 1101.
- Parameterisation: instantiate with WIDTH=8, w3=8'hA5, s=11, in_valid=1 -> y = 8'hA5 one clock later.
